// File: rtl/ir_nec_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ir_nec_tx
// Purpose  : NEC infrared transmitter (full frames and repeat codes) with an
//            optional carrier-modulated LED drive.
// Revision : 1.0  initial release
// ============================================================================
module ir_nec_tx #(
    parameter int UNIT_CYCLES  = 28125,
    parameter int CARRIER_HALF = 658,
    parameter int CARRIER_EN   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       repeat_req,
    input  logic [7:0] address,
    input  logic [7:0] command,
    output logic       busy,
    output logic       done,
    output logic       ir_envelope,
    output logic       ir_tx
);

    localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] CAR_LAST  = CW'(CARRIER_HALF - 1);
    localparam logic          USE_CAR   = (CARRIER_EN != 0);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        REP_SPACE  = 3'd3,
        BIT_MARK   = 3'd4,
        BIT_SPACE  = 3'd5,
        STOP_MARK  = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [UW-1:0] cyc_q, cyc_d;
    logic [4:0]    units_q, units_d;
    logic [5:0]    bit_q, bit_d;
    logic [31:0]   shift_q, shift_d;
    logic          rep_q, rep_d;
    logic          car_q, car_d;
    logic [CW-1:0] car_cnt_q, car_cnt_d;
    logic          busy_q, done_q, env_q, tx_q;

    logic          unit_end;
    logic          state_end;
    logic [4:0]    dur_m1;
    logic          mark_d;

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        units_d   = units_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rep_d     = rep_q;
        car_d     = 1'b0;
        car_cnt_d = '0;

        // Length of the current state in units, minus one.
        case (state_q)
            LEAD_MARK:  dur_m1 = 5'd15;
            LEAD_SPACE: dur_m1 = 5'd7;
            REP_SPACE:  dur_m1 = 5'd3;
            BIT_SPACE:  dur_m1 = shift_q[0] ? 5'd2 : 5'd0;
            default:    dur_m1 = 5'd0;
        endcase

        unit_end  = (cyc_q == UNIT_LAST);
        state_end = unit_end && (units_q == dur_m1);

        if (state_q != IDLE) begin
            if (unit_end) begin
                cyc_d   = '0;
                units_d = units_q + 5'd1;
            end else begin
                cyc_d = cyc_q + UW'(1);
            end
            if (state_end) begin
                units_d = '0;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = {~command, command, ~address, address};
                    rep_d   = 1'b0;
                    state_d = LEAD_MARK;
                end else if (repeat_req) begin
                    rep_d   = 1'b1;
                    state_d = LEAD_MARK;
                end
            end
            LEAD_MARK: begin
                if (state_end) state_d = rep_q ? REP_SPACE : LEAD_SPACE;
            end
            LEAD_SPACE: begin
                if (state_end) begin
                    bit_d   = 6'd0;
                    state_d = BIT_MARK;
                end
            end
            BIT_MARK: begin
                if (state_end) state_d = BIT_SPACE;
            end
            BIT_SPACE: begin
                if (state_end) begin
                    if (bit_q == 6'd31) begin
                        state_d = STOP_MARK;
                    end else begin
                        bit_d   = bit_q + 6'd1;
                        shift_d = {1'b0, shift_q[31:1]};
                        state_d = BIT_MARK;
                    end
                end
            end
            REP_SPACE: begin
                if (state_end) state_d = STOP_MARK;
            end
            STOP_MARK: begin
                if (state_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        mark_d = (state_d == LEAD_MARK) || (state_d == BIT_MARK) ||
                 (state_d == STOP_MARK);

        // Marks and spaces always alternate, so a state change into a mark
        // is exactly the first cycle of a new mark.
        if (mark_d && (state_d != state_q)) begin
            car_d     = 1'b1;
            car_cnt_d = '0;
        end else if (mark_d) begin
            if (car_cnt_q == CAR_LAST) begin
                car_d     = ~car_q;
                car_cnt_d = '0;
            end else begin
                car_d     = car_q;
                car_cnt_d = car_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            units_q   <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rep_q     <= 1'b0;
            car_q     <= 1'b0;
            car_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            env_q     <= 1'b0;
            tx_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            units_q   <= units_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rep_q     <= rep_d;
            car_q     <= car_d;
            car_cnt_q <= car_cnt_d;
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_q == STOP_MARK) && (state_d == IDLE);
            env_q     <= mark_d;
            tx_q      <= mark_d & (car_d | ~USE_CAR);
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign ir_envelope = env_q;
    assign ir_tx       = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_ir_nec_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ir_nec_tx
// Purpose  : Self-checking bench for ir_nec_tx (carrier and raw variants).
// Revision : 1.0  initial release
// ============================================================================
module tb_ir_nec_tx;

    localparam int U  = 4;
    localparam int CH = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       repeat_req;
    logic [7:0] address;
    logic [7:0] command;
    logic       busy, done, env, tx;
    logic       busy2, done2, env2, tx2;

    always #5 clk = ~clk;

    ir_nec_tx #(.UNIT_CYCLES(U), .CARRIER_HALF(CH), .CARRIER_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .repeat_req(repeat_req),
        .address(address), .command(command), .busy(busy), .done(done),
        .ir_envelope(env), .ir_tx(tx)
    );

    ir_nec_tx #(.UNIT_CYCLES(U), .CARRIER_HALF(CH), .CARRIER_EN(0)) dut_raw (
        .clk(clk), .rst_n(rst_n), .start(start), .repeat_req(repeat_req),
        .address(address), .command(command), .busy(busy2), .done(done2),
        .ir_envelope(env2), .ir_tx(tx2)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is a flat list of per-cycle (envelope, carrier-tx) samples.
    typedef struct packed {
        logic env;
        logic tx;
    } smp_t;

    smp_t mq[$];
    smp_t ent;
    logic e_busy = 1'b0;
    logic e_done = 1'b0;
    logic e_env  = 1'b0;
    logic e_tx   = 1'b0;
    bit   chk_en = 1'b0;

    task automatic add_mark(input int n);
        smp_t s;
        for (int j = 0; j < n; j++) begin
            s.env = 1'b1;
            s.tx  = (((j / CH) % 2) == 0);
            mq.push_back(s);
        end
    endtask

    task automatic add_space(input int n);
        smp_t s;
        for (int j = 0; j < n; j++) begin
            s.env = 1'b0;
            s.tx  = 1'b0;
            mq.push_back(s);
        end
    endtask

    task automatic build(input logic full, input logic [31:0] word);
        mq.delete();
        add_mark(16 * U);
        if (full) begin
            add_space(8 * U);
            for (int i = 0; i < 32; i++) begin
                add_mark(U);
                add_space(word[i] ? 3 * U : U);
            end
        end else begin
            add_space(4 * U);
        end
        add_mark(U);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            e_busy = 1'b0; e_done = 1'b0; e_env = 1'b0; e_tx = 1'b0;
        end else begin
            if (!e_busy && (start || repeat_req))
                build(start, {~command, command, ~address, address});
            if (mq.size() > 0) begin
                ent    = mq.pop_front();
                e_busy = 1'b1;
                e_done = 1'b0;
                e_env  = ent.env;
                e_tx   = ent.tx;
            end else begin
                e_done = e_busy;
                e_busy = 1'b0;
                e_env  = 1'b0;
                e_tx   = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("busy", busy, e_busy);
            cmp("done", done, e_done);
            cmp("envelope", env, e_env);
            cmp("ir_tx", tx, e_tx);
            cmp("raw_busy", busy2, e_busy);
            cmp("raw_envelope", env2, e_env);
            cmp("raw_ir_tx", tx2, e_env);
        end
    end

    // Frame observation straight from the DUT pins, independent of the model.
    int          busy_n;
    int          runs[$];
    logic [31:0] bits;

    task automatic go(input logic s, input logic r, input logic [7:0] a, input logic [7:0] c);
        start = s; repeat_req = r; address = a; command = c;
        @(negedge clk);
        start = 1'b0; repeat_req = 1'b0;
    endtask

    task automatic measure(input int poke);
        logic cur;
        int   len;
        busy_n = 0;
        runs.delete();
        cur = 1'b1;
        len = 0;
        while (busy === 1'b1 && busy_n < 1000) begin
            busy_n++;
            if (busy_n == 1) cmp("tx_first_mark_cycle", tx, 1);
            if (busy_n == 2) cmp("tx_second_mark_cycle", tx, 0);
            if (env === cur) len++;
            else begin
                runs.push_back(len);
                cur = env;
                len = 1;
            end
            if (busy_n == poke) begin
                start = 1'b1; address = 8'hFF; command = 8'hFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        runs.push_back(len);
        cmp("done_at_frame_end", done, 1);
        bits = '0;
        if (runs.size() == 67)
            for (int i = 0; i < 32; i++) bits[i] = (runs[3 + 2 * i] == 3 * U);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; repeat_req = 1'b0; address = '0; command = '0;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        #3;
        cmp("reset_busy", busy, 0);
        cmp("reset_done", done, 0);
        cmp("reset_env", env, 0);
        cmp("reset_tx", tx, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // All-zero address/command
        go(1'b1, 1'b0, 8'h00, 8'h00);
        measure(0);
        cmp("zero_busy_cycles", busy_n, 484);
        cmp("zero_run_count", runs.size(), 67);
        cmp("zero_lead_mark", runs[0], 64);
        cmp("zero_lead_space", runs[1], 32);
        cmp("zero_bit0_mark", runs[2], 4);
        cmp("zero_bit0_space", runs[3], 4);
        cmp("zero_bit8_space", runs[19], 12);
        cmp("zero_stop_mark", runs[66], 4);
        cmp("zero_bits", bits, 32'hFF00FF00);
        @(negedge clk);
        cmp("done_single_pulse", done, 0);

        // Mixed pattern
        go(1'b1, 1'b0, 8'hA5, 8'h3C);
        measure(0);
        cmp("a5_busy_cycles", busy_n, 484);
        cmp("a5_bits", bits, 32'hC33C5AA5);
        @(negedge clk);

        // Repeat code
        go(1'b0, 1'b1, 8'h12, 8'h34);
        measure(0);
        cmp("rep_busy_cycles", busy_n, 84);
        cmp("rep_run_count", runs.size(), 3);
        cmp("rep_lead_mark", runs[0], 64);
        cmp("rep_space", runs[1], 16);
        cmp("rep_stop_mark", runs[2], 4);
        @(negedge clk);

        // start and repeat together -> full frame
        go(1'b1, 1'b1, 8'h55, 8'hAA);
        measure(0);
        cmp("both_busy_cycles", busy_n, 484);
        cmp("both_bits", bits, 32'h55AAAA55);
        @(negedge clk);

        // start while busy with changed inputs, then start in the done cycle
        go(1'b1, 1'b0, 8'hA5, 8'h3C);
        measure(100);
        cmp("busy_ignore_bits", bits, 32'hC33C5AA5);
        cmp("busy_ignore_cycles", busy_n, 484);
        start = 1'b1; address = 8'h01; command = 8'h80;
        @(negedge clk);
        start = 1'b0;
        cmp("busy_after_done_start", busy, 1);
        measure(0);
        cmp("chain_busy_cycles", busy_n, 484);
        cmp("chain_bits", bits, 32'h7F80FE01);
        @(negedge clk);

        // Reset in the middle of a frame
        go(1'b1, 1'b0, 8'hFF, 8'h00);
        repeat (199) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("async_rst_busy", busy, 0);
        cmp("async_rst_done", done, 0);
        cmp("async_rst_tx", tx, 0);
        cmp("async_rst_env", env, 0);
        cmp("async_rst_raw_tx", tx2, 0);
        repeat (2) @(negedge clk);
        start = 1'b1; address = 8'h5A; command = 8'hC3;
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cmp("post_rst_no_done", done, 0);
        measure(0);
        cmp("post_rst_busy_cycles", busy_n, 484);
        cmp("post_rst_bits", bits, 32'h3CC3A55A);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ir_nec_tx.md
IR_NEC_TX -- requirements
Module: ir_nec_tx

Interface
REQ-001 The block SHALL have parameter UNIT_CYCLES, default 28125, meaning clk cycles per 562.5 us NEC unit at 50 MHz.
REQ-002 The block SHALL have parameter CARRIER_HALF, default 658, meaning clk cycles per half-period of the ~38 kHz carrier.
REQ-003 The block SHALL have parameter CARRIER_EN, default 1, meaning 1 modulates marks with the carrier and 0 outputs the raw envelope on ir_tx.
REQ-004 The block SHALL have port clk, input, 1 bit, the single system clock (CLOCK_50 domain); all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit, a request to send a full NEC frame.
REQ-007 The block SHALL have port repeat_req, input, 1 bit, a request to send an NEC repeat code.
REQ-008 The block SHALL have port address, input, 8 bits, the NEC address byte.
REQ-009 The block SHALL have port command, input, 8 bits, the NEC command byte.
REQ-010 The block SHALL have port busy, output, 1 bit, high while a frame is in progress.
REQ-011 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking frame completion.
REQ-012 The block SHALL have port ir_envelope, output, 1 bit, which is 1 during marks.
REQ-013 The block SHALL have port ir_tx, output, 1 bit, driving the IR LED (modulated envelope).

Function
REQ-014 The FSM SHALL have states IDLE, LEAD_MARK, LEAD_SPACE, REP_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK; all durations SHALL be counted in whole units of UNIT_CYCLES cycles.
REQ-015 In IDLE, start=1 SHALL latch the 32-bit word {~command, command, ~address, address} and enter LEAD_MARK on the next edge; transmission is LSB first (address bit0 first).
REQ-016 In IDLE, repeat_req=1 with start=0 SHALL enter LEAD_MARK flagged as a repeat; start and repeat_req together SHALL send a full frame.
REQ-017 start and repeat_req SHALL be ignored while busy=1, and input changes after the latch SHALL not affect the frame in flight.
REQ-018 LEAD_MARK SHALL last 16 units, then go to LEAD_SPACE (full frame, 8 units) or REP_SPACE (repeat, 4 units).
REQ-019 Each data bit SHALL be BIT_MARK for 1 unit, then BIT_SPACE for 1 unit (bit 0) or 3 units (bit 1); a 6-bit index SHALL step 0..31.
REQ-020 After bit 31's space, or after REP_SPACE, STOP_MARK SHALL last 1 unit, then the FSM returns to IDLE.
REQ-021 A full frame SHALL always total 121 units (16+8+16x2+16x4+1); a repeat frame SHALL total 21 units.
REQ-022 busy SHALL be high from the cycle after acceptance through the last STOP_MARK cycle, and low in IDLE.
REQ-023 done SHALL pulse for exactly the first IDLE cycle after STOP_MARK, with busy=0 in that cycle; a start in that cycle SHALL be accepted.
REQ-024 ir_envelope SHALL be 1 exactly in LEAD_MARK, BIT_MARK, and STOP_MARK, and be registered with no combinational path from inputs.
REQ-025 The carrier SHALL restart high at the first cycle of every mark and toggle every CARRIER_HALF cycles while in a mark.
REQ-026 ir_tx SHALL equal ir_envelope AND carrier when CARRIER_EN=1, or ir_envelope when CARRIER_EN=0; it SHALL be 0 in every space and in IDLE.
REQ-027 Unit and carrier counters SHALL be sized from $clog2 of their parameters, and SHALL never wrap inside a state.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, ir_envelope=0, ir_tx=0, and clear all counters and the shift register, including mid-frame.
REQ-029 After rst_n rises, the block SHALL accept start on the first clk edge.
REQ-030 A frame aborted by reset SHALL not resume, and done SHALL not pulse for it.

Verification (UNIT_CYCLES=4, CARRIER_HALF=1)
REQ-031 start with address=0x00, command=0x00 -> envelope high 64 cycles, low 32, then 16x(4 high/4 low), 16x(4 high/12 low), 4 high; busy 484 cycles; done one pulse.
REQ-032 start with address=0xA5, command=0x3C -> recovered LSB-first bits equal 0xC33C5AA5; busy still 484 cycles.
REQ-033 repeat_req alone -> envelope 64 high, 16 low, 4 high; busy 84 cycles; start+repeat_req together -> 484-cycle full frame.
REQ-034 start pulsed while busy, with address changed mid-frame -> ignored; original bits sent; start in the done cycle -> new frame begins the next cycle.
REQ-035 rst_n low at cycle 200 of a frame -> ir_tx, busy, and done are 0 asynchronously; no done pulse; the next start yields a clean 484-cycle frame.
REQ-036 CARRIER_EN=1 -> ir_tx toggles every cycle during marks, starting high at each mark, and is 0 in spaces; CARRIER_EN=0 -> ir_tx equals ir_envelope.
